// File: rtl/wb_arbiter_n.sv
// N-master to 1-slave Wishbone arbiter: fixed-priority or round-robin choice,
// optional hold timeout, registered one-hot grant driving a combinational slave mux.
module wb_arbiter_n #(
  parameter int MASTER_COUNT = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int ROUND_ROBIN  = 0,
  parameter int MAX_HOLD     = 0
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [MASTER_COUNT-1:0]               m_we_i,
  input  logic [MASTER_COUNT-1:0]               m_cyc_i,
  input  logic [MASTER_COUNT-1:0]               m_stb_i,
  input  logic [MASTER_COUNT*DATA_WIDTH/8-1:0]  m_sel_i,
  input  logic [MASTER_COUNT*ADDR_WIDTH-1:0]    m_adr_i,
  input  logic [MASTER_COUNT*DATA_WIDTH-1:0]    m_dat_i,
  output logic [DATA_WIDTH-1:0]                 m_dat_o,
  output logic [MASTER_COUNT-1:0]               m_ack_o,
  output logic [MASTER_COUNT-1:0]               m_int_o,
  output logic                                  s_we_o,
  output logic                                  s_cyc_o,
  output logic                                  s_stb_o,
  output logic [DATA_WIDTH/8-1:0]               s_sel_o,
  output logic [ADDR_WIDTH-1:0]                 s_adr_o,
  output logic [DATA_WIDTH-1:0]                 s_dat_o,
  input  logic [DATA_WIDTH-1:0]                 s_dat_i,
  input  logic                                  s_ack_i,
  input  logic                                  s_int_i,
  output logic [MASTER_COUNT-1:0]               grant_o
);

  localparam int N  = MASTER_COUNT;
  localparam int SW = DATA_WIDTH / 8;
  localparam int LW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [N-1:0]  ONE_N    = {{(N-1){1'b0}}, 1'b1};
  localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);

  typedef enum logic {S_IDLE, S_OWN} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [N-1:0]  mask_q, mask_d;
  logic [LW-1:0] last_q, last_d;
  logic [HW-1:0] hold_q, hold_d;

  logic [N-1:0]  elig;
  logic [LW-1:0] fp_idx, rr_hi_idx, rr_lo_idx, win_idx, own_idx;
  logic          rr_hi_found;
  logic          own_cyc, gap, lower_req, other_req;
  logic          rel_normal, rel_preempt, rel_timeout;

  // Winner selection. A masked master only loses if someone else is asking.
  always_comb begin
    elig = m_cyc_i & ~mask_q;
    if (elig == '0) elig = m_cyc_i;
    fp_idx      = '0;
    rr_hi_idx   = '0;
    rr_lo_idx   = '0;
    rr_hi_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (elig[i]) begin
        fp_idx = LW'(i);
        if (LW'(i) > last_q) begin
          rr_hi_idx   = LW'(i);
          rr_hi_found = 1'b1;
        end else begin
          rr_lo_idx = LW'(i);
        end
      end
    end
    if (ROUND_ROBIN != 0) win_idx = rr_hi_found ? rr_hi_idx : rr_lo_idx;
    else                  win_idx = fp_idx;
  end

  // Wishbone handshake: a beat transfers when the granted master holds stb and
  // the slave returns ack; cyc framing is owned by the master until release.
  always_comb begin
    own_idx = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_q[i]) begin
        own_idx = LW'(i);
        s_we_o  = m_we_i[i];
        s_cyc_o = m_cyc_i[i];
        s_stb_o = m_stb_i[i];
        s_sel_o = m_sel_i[i*SW +: SW];
        s_adr_o = m_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        s_dat_o = m_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign m_ack_o = grant_q & {N{s_ack_i}};
  assign m_int_o = grant_q & {N{s_int_i}};
  assign m_dat_o = s_dat_i;
  assign grant_o = grant_q;

  assign own_cyc     = |(m_cyc_i & grant_q);
  assign gap         = !s_stb_o && !s_ack_i;
  assign lower_req   = |(m_cyc_i & (grant_q - ONE_N));
  assign other_req   = |(m_cyc_i & ~grant_q);
  assign rel_normal  = !own_cyc && !s_ack_i;
  assign rel_preempt = (ROUND_ROBIN == 0) && lower_req && gap;
  assign rel_timeout = (MAX_HOLD > 0) && (hold_q >= HOLD_LIM) && gap;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    mask_d  = mask_q;
    last_d  = last_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: begin
        if (|m_cyc_i) begin
          state_d = S_OWN;
          grant_d = ONE_N << win_idx;
          mask_d  = '0;
          hold_d  = '0;
        end
      end
      S_OWN: begin
        if (rel_normal || rel_preempt || rel_timeout) begin
          state_d = S_IDLE;
          grant_d = '0;
          last_d  = own_idx;
          hold_d  = '0;
          // Only a forced release in fixed mode demotes the loser for one round.
          if (!rel_normal && ROUND_ROBIN == 0) mask_d = grant_q;
        end else if (other_req && hold_q != '1) begin
          hold_d = hold_q + HOLD_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      mask_q  <= '0;
      last_q  <= LW'(N - 1);
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      mask_q  <= mask_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter_n.sv
// Bench for wb_arbiter_n: three instances (fixed, round-robin, fixed with MAX_HOLD=8)
// sharing one master/slave stimulus, checked against an integer-level model.
module tb_wb_arbiter_n;

  localparam int N    = 4;
  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int SW   = DW / 8;
  localparam int NCFG = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    m_we = '0, m_cyc = '0, m_stb = '0;
  logic [N*SW-1:0] m_sel = '0;
  logic [N*AW-1:0] m_adr = '0;
  logic [N*DW-1:0] m_dat = '0;
  logic [DW-1:0]   s_dat_i = '0;
  logic            s_ack = 1'b0, s_int = 1'b0;

  logic [DW-1:0] o_mdat  [NCFG];
  logic [N-1:0]  o_mack  [NCFG];
  logic [N-1:0]  o_mint  [NCFG];
  logic [N-1:0]  o_grant [NCFG];
  logic          o_swe   [NCFG];
  logic          o_scyc  [NCFG];
  logic          o_sstb  [NCFG];
  logic [SW-1:0] o_ssel  [NCFG];
  logic [AW-1:0] o_sadr  [NCFG];
  logic [DW-1:0] o_sdat  [NCFG];

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < NCFG; k++) begin : g_dut
    wb_arbiter_n #(
      .MASTER_COUNT(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
      .ROUND_ROBIN((k == 1) ? 1 : 0), .MAX_HOLD((k == 2) ? 8 : 0)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .m_we_i(m_we), .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_sel_i(m_sel),
      .m_adr_i(m_adr), .m_dat_i(m_dat), .m_dat_o(o_mdat[k]), .m_ack_o(o_mack[k]),
      .m_int_o(o_mint[k]), .s_we_o(o_swe[k]), .s_cyc_o(o_scyc[k]), .s_stb_o(o_sstb[k]),
      .s_sel_o(o_ssel[k]), .s_adr_o(o_sadr[k]), .s_dat_o(o_sdat[k]), .s_dat_i(s_dat_i),
      .s_ack_i(s_ack), .s_int_i(s_int), .grant_o(o_grant[k])
    );
  end

  // Reference model: owner index (-1 idle), last owner, contended-cycle count, masked master.
  int own [NCFG];
  int last [NCFG];
  int hold [NCFG];
  int msk [NCFG];

  function automatic void model_step(int k);
    logic [N-1:0] req;
    int w, g, mh;
    logic gp, normal, lower, other;
    mh = (k == 2) ? 8 : 0;
    if (own[k] < 0) begin
      if (m_cyc != '0) begin
        req = m_cyc;
        if (k != 1 && msk[k] >= 0) begin
          if ((m_cyc & ~(4'b0001 << msk[k])) != '0) req[msk[k]] = 1'b0;
        end
        msk[k] = -1;
        w = -1;
        if (k == 1) begin
          for (int s = 1; s <= N; s++)
            if (w < 0 && req[(last[k] + s) % N]) w = (last[k] + s) % N;
        end else begin
          for (int i = 0; i < N; i++)
            if (w < 0 && req[i]) w = i;
        end
        own[k] = w;
        hold[k] = 0;
      end
    end else begin
      g = own[k];
      gp = !m_stb[g] && !s_ack;
      normal = !m_cyc[g] && !s_ack;
      lower = 1'b0;
      other = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (m_cyc[i] && i != g) begin
          other = 1'b1;
          if (i < g) lower = 1'b1;
        end
      end
      if (normal || (k != 1 && lower && gp) || (mh > 0 && hold[k] >= mh && gp)) begin
        if (!normal && k != 1) msk[k] = g;
        last[k] = g;
        own[k] = -1;
        hold[k] = 0;
      end else if (other) begin
        hold[k]++;
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCFG; k++) begin
        own[k] = -1; last[k] = N - 1; hold[k] = 0; msk[k] = -1;
      end
    end else begin
      for (int k = 0; k < NCFG; k++) model_step(k);
    end
  end

  task automatic drive_idle();
    m_we = '0; m_cyc = '0; m_stb = '0; m_sel = '0; m_adr = '0; m_dat = '0;
    s_ack = 1'b0; s_int = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    drive_idle();
    m_cyc = 4'b1111;
    m_stb = 4'b1111;
    s_ack = 1'b1;
    s_int = 1'b1;
    s_dat_i = 32'hA5A5_0F0F;
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < NCFG; k++) begin
      tests_run++;
      if ({o_grant[k], o_scyc[k], o_sstb[k], o_mack[k], o_mint[k]} !== '0) begin
        tests_failed++;
        $display("FAIL reset_outputs cfg%0d: got grant=%b cyc=%b stb=%b ack=%b int=%b, want all 0",
                 k, o_grant[k], o_scyc[k], o_sstb[k], o_mack[k], o_mint[k]);
      end
      tests_run++;
      if (o_mdat[k] !== 32'hA5A5_0F0F) begin
        tests_failed++;
        $display("FAIL reset_mdat cfg%0d: got %h want a5a50f0f", k, o_mdat[k]);
      end
    end
    @(negedge clk);
    for (int k = 0; k < NCFG; k++) begin
      tests_run++;
      if ({o_grant[k], o_scyc[k]} !== '0) begin
        tests_failed++;
        $display("FAIL reset_held cfg%0d: got grant=%b cyc=%b want 0", k, o_grant[k], o_scyc[k]);
      end
    end
    drive_idle();
    rst_n = 1'b1;
  endtask

  task automatic test_fixed_basic();
    do_reset();
    m_adr = {32'h3000_0003, 32'h2000_0002, 32'h1000_0001, 32'h0000_0000};
    m_cyc = 4'b1010;
    m_stb = 4'b1010;
    m_we  = 4'b0010;
    #1;
    tests_run++;
    if (o_grant[0] !== 4'b0000) begin
      tests_failed++;
      $display("FAIL fixed_latency: got grant=%b want 0000", o_grant[0]);
    end
    @(negedge clk);
    tests_run++;
    if ({o_grant[0], o_scyc[0], o_swe[0], o_sadr[0]} !== {4'b0010, 1'b1, 1'b1, 32'h1000_0001}) begin
      tests_failed++;
      $display("FAIL fixed_grant: got grant=%b cyc=%b we=%b adr=%h want 0010 1 1 10000001",
               o_grant[0], o_scyc[0], o_swe[0], o_sadr[0]);
    end
    s_ack = 1'b1;
    #1;
    tests_run++;
    if (o_mack[0] !== 4'b0010) begin
      tests_failed++;
      $display("FAIL fixed_ack: got m_ack=%b want 0010", o_mack[0]);
    end
    @(negedge clk);
    s_ack = 1'b0;
    m_cyc = 4'b0000;
    @(negedge clk);
    tests_run++;
    if ({o_grant[0], o_scyc[0]} !== 5'b0) begin
      tests_failed++;
      $display("FAIL fixed_release: got grant=%b cyc=%b want 0000 0", o_grant[0], o_scyc[0]);
    end
  endtask

  task automatic test_rr_rotation();
    logic [N-1:0] exp_g;
    int g;
    do_reset();
    m_cyc = 4'b1111;
    m_stb = 4'b1111;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      g = (i / 3) % N;
      exp_g = (i % 3 == 2) ? 4'b0000 : (4'b0001 << g);
      tests_run++;
      if (o_grant[1] !== exp_g) begin
        tests_failed++;
        $display("FAIL rr_order cycle %0d: got grant=%b want %b", i, o_grant[1], exp_g);
      end
      case (i % 3)
        0: s_ack = 1'b1;
        1: begin s_ack = 1'b0; m_cyc[g] = 1'b0; end
        default: m_cyc = 4'b1111;
      endcase
    end
    drive_idle();
  endtask

  task automatic test_preempt();
    do_reset();
    m_cyc = 4'b0100;
    m_stb = 4'b0100;
    @(negedge clk);
    tests_run++;
    if (o_grant[0] !== 4'b0100) begin
      tests_failed++;
      $display("FAIL preempt_own: got grant=%b want 0100", o_grant[0]);
    end
    m_cyc = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if ({o_grant[0], o_scyc[0]} !== {4'b0100, 1'b1}) begin
        tests_failed++;
        $display("FAIL preempt_stb_hold %0d: got grant=%b cyc=%b want 0100 1", i, o_grant[0], o_scyc[0]);
      end
    end
    s_ack = 1'b1;
    #1;
    tests_run++;
    if (o_mack[0] !== 4'b0100) begin
      tests_failed++;
      $display("FAIL preempt_ack: got m_ack=%b want 0100", o_mack[0]);
    end
    @(negedge clk);
    tests_run++;
    if (o_grant[0] !== 4'b0100) begin
      tests_failed++;
      $display("FAIL preempt_ack_hold: got grant=%b want 0100", o_grant[0]);
    end
    m_stb = 4'b0000;
    s_ack = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({o_grant[0], o_scyc[0]} !== 5'b0) begin
      tests_failed++;
      $display("FAIL preempt_release: got grant=%b cyc=%b want 0000 0", o_grant[0], o_scyc[0]);
    end
    @(negedge clk);
    tests_run++;
    if (o_grant[0] !== 4'b0001) begin
      tests_failed++;
      $display("FAIL preempt_regrant: got grant=%b want 0001", o_grant[0]);
    end
    drive_idle();
  endtask

  task automatic test_hold_timeout();
    logic [N-1:0] exp_g;
    do_reset();
    m_cyc = 4'b0010;
    m_stb = 4'b0010;
    @(negedge clk);
    tests_run++;
    if (o_grant[2] !== 4'b0010) begin
      tests_failed++;
      $display("FAIL hold_own: got grant=%b want 0010", o_grant[2]);
    end
    m_cyc = 4'b1010;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      exp_g = (i <= 8) ? 4'b0010 : ((i == 9) ? 4'b0000 : 4'b1000);
      tests_run++;
      if (o_grant[2] !== exp_g) begin
        tests_failed++;
        $display("FAIL hold_timeout edge %0d: got grant=%b want %b", i, o_grant[2], exp_g);
      end
      m_stb[1] = !(i == 4 || i == 8);
    end
    drive_idle();
  endtask

  task automatic test_async_reset();
    do_reset();
    m_cyc = 4'b0100;
    m_stb = 4'b0100;
    @(negedge clk);
    tests_run++;
    if ({o_grant[0], o_sstb[0]} !== {4'b0100, 1'b1}) begin
      tests_failed++;
      $display("FAIL areset_setup: got grant=%b stb=%b want 0100 1", o_grant[0], o_sstb[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({o_grant[0], o_scyc[0], o_sstb[0]} !== 6'b0) begin
      tests_failed++;
      $display("FAIL areset_async: got grant=%b cyc=%b stb=%b want 0", o_grant[0], o_scyc[0], o_sstb[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_cyc = 4'b1111;
    m_stb = 4'b1111;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      tests_run++;
      if (o_grant[k] !== 4'b0001) begin
        tests_failed++;
        $display("FAIL areset_first_win cfg%0d: got grant=%b want 0001", k, o_grant[k]);
      end
    end
    drive_idle();
  endtask

  task automatic test_idle_isolation();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      m_cyc = '0; m_stb = '1; m_we = '1; m_sel = '1;
      m_adr = {$urandom, $urandom, $urandom, $urandom};
      m_dat = {$urandom, $urandom, $urandom, $urandom};
      s_ack = 1'b1; s_int = 1'b1;
      s_dat_i = $urandom;
      #1;
      for (int k = 0; k < NCFG; k++) begin
        tests_run++;
        if ({o_grant[k], o_mack[k], o_mint[k], o_scyc[k], o_sstb[k], o_swe[k],
             o_ssel[k], o_sadr[k], o_sdat[k]} !== '0 || o_mdat[k] !== s_dat_i) begin
          tests_failed++;
          $display("FAIL idle_iso cfg%0d: got grant=%b ack=%b int=%b cyc=%b stb=%b adr=%h mdat=%h want 0s mdat=%h",
                   k, o_grant[k], o_mack[k], o_mint[k], o_scyc[k], o_sstb[k], o_sadr[k], o_mdat[k], s_dat_i);
        end
      end
    end
    drive_idle();
  endtask

  task automatic test_random();
    logic [114:0] exp_v, act_v;
    logic [N-1:0] eg, ea, ei;
    logic ec, es, ew;
    logic [SW-1:0] esel;
    logic [AW-1:0] eadr;
    logic [DW-1:0] edat;
    int g;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int j = 0; j < N; j++) if ($urandom_range(0, 9) < 3) m_cyc[j] = ~m_cyc[j];
      m_stb = 4'($urandom) & m_cyc;
      m_we = 4'($urandom);
      m_sel = 16'($urandom);
      m_adr = {$urandom, $urandom, $urandom, $urandom};
      m_dat = {$urandom, $urandom, $urandom, $urandom};
      s_dat_i = $urandom;
      s_ack = ($urandom_range(0, 3) == 0);
      s_int = 1'($urandom_range(0, 1));
      #1;
      for (int k = 0; k < NCFG; k++) begin
        eg = '0; ea = '0; ei = '0; ec = 1'b0; es = 1'b0; ew = 1'b0;
        esel = '0; eadr = '0; edat = '0;
        if (own[k] >= 0) begin
          g = own[k];
          eg[g] = 1'b1; ea[g] = s_ack; ei[g] = s_int;
          ec = m_cyc[g]; es = m_stb[g]; ew = m_we[g];
          esel = m_sel[g*SW +: SW];
          eadr = m_adr[g*AW +: AW];
          edat = m_dat[g*DW +: DW];
        end
        exp_v = {eg, ec, es, ew, esel, eadr, edat, ea, ei, s_dat_i};
        act_v = {o_grant[k], o_scyc[k], o_sstb[k], o_swe[k], o_ssel[k], o_sadr[k],
                 o_sdat[k], o_mack[k], o_mint[k], o_mdat[k]};
        tests_run++;
        if (act_v !== exp_v) begin
          tests_failed++;
          $display("FAIL random cfg%0d cycle %0d: got %h want %h", k, c, act_v, exp_v);
        end
      end
    end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_fixed_basic();
    test_rr_rotation();
    test_preempt();
    test_hold_timeout();
    test_async_reset();
    test_idle_isolation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
